codec_cmd_sequencer: RTL and testbench
======================================

// Module: codec_cmd_sequencer
// PURPOSE
// - Upstream stage of the CODEC controller unit. Buffers CODEC register read/write
//   commands from the register/AXI front end in a FIFO and issues them one at a time.
// - Drives codec_rd_en/codec_wr_en and tracks controller_busy to detect completion.
// - Returns read data and an error flag (missed ACK or timeout) through a response handshake.
// PARAMETERS
// - FIFO_DEPTH      8          command FIFO entries; power of 2, >= 2
// - TIMEOUT_CYCLES  2_000_000  max cycles from issue to completion before abort (16 ms @125MHz)
// PORTS
// - clk                   in   1   system clock (125 MHz)
// - reset_n               in   1   asynchronous active-low reset
// - cmd_valid             in   1   command present
// - cmd_ready             out  1   FIFO can accept (= !full)
// - cmd_rd                in   1   1 = register read, 0 = register write
// - cmd_addr              in   8   CODEC register address
// - cmd_data              in   9   write data (ignored for reads)
// - rsp_valid             out  1   response held
// - rsp_ready             in   1   response consumed
// - rsp_addr              out  8   address of completed command
// - rsp_data              out  9   read data (0 for writes or on error)
// - rsp_error             out  1   missed_ack seen or timeout
// - fifo_level            out  $clog2(FIFO_DEPTH)+1   entries queued
// - codec_rd_en           out  1   read pulse to controller
// - codec_wr_en           out  1   write pulse to controller
// - codec_reg_addr        out  8   address to controller
// - codec_data_in         out  9   write data to controller
// - codec_data_out        in   9   read data from controller
// - codec_data_out_valid  in   1   read data strobe
// - controller_busy       in   1   controller busy (held 1 during CODEC init)
// - missed_ack            in   1   I2C NACK indication
// - init_done, init_error in   1   CODEC init status; either one enables issuing
// BEHAVIOUR
// - Reset: FIFO empty, FSM IDLE. All outputs 0 except cmd_ready = 1. Timeout counter = 0.
// - FIFO: push on cmd_valid & cmd_ready. Pop only on IDLE->ISSUE. Push when full is impossible
//   because cmd_ready = 0. No write-through bypass when full: a same-cycle pop does not enable a push.
// - FSM (all control outputs registered):
//   IDLE: if FIFO non-empty, (init_done|init_error) = 1, controller_busy = 0 and rsp_valid = 0:
//     pop the head, latch addr/data/rd, go to ISSUE.
//   ISSUE: assert codec_rd_en or codec_wr_en for exactly 1 cycle, clear the timer, go to WAIT_ACC.
//   WAIT_ACC: wait for controller_busy = 1, then go to WAIT_DONE.
//   WAIT_DONE: wait for controller_busy = 0, then go to RESP.
//   RESP: present the response; leave to IDLE on rsp_valid & rsp_ready.
// - codec_reg_addr/codec_data_in hold the latched values from ISSUE until the next ISSUE.
// - Latency: a command accepted in cycle N drives codec_*_en no earlier than N+2.
// - In WAIT_ACC/WAIT_DONE, capture codec_data_out into rsp_data when codec_data_out_valid = 1.
//   Valid strobes in any other state are ignored. Last capture wins.
// - missed_ack high in any cycle of WAIT_ACC/WAIT_DONE sets rsp_error.
// - Timer increments in WAIT_ACC/WAIT_DONE. When it reaches TIMEOUT_CYCLES:
//   rsp_error = 1, rsp_data = 0, go to RESP.
// - On error, rsp_data is forced to 0. rsp_addr = latched address.
// - One outstanding command at a time. The next pop waits for the response handshake.
// - reset_n deasserted mid-transaction aborts immediately. Queued commands are discarded.
// CONFIGURATION
// - CODEC_CMD_WR_RSP_EN defined: writes also produce a response (rsp_data = 0).
// - CODEC_CMD_WR_RSP_EN undefined: writes skip RESP (WAIT_DONE -> IDLE); only reads respond.
//   A write error is then reported only by the sticky bit wr_err_sticky (cleared by reset).
//   wr_err_sticky is an extra output port that exists only in this build.
// TESTING
// - Init gating: init_done = init_error = 0, push a write to 0x07 -> no codec_wr_en.
//   Raise init_done -> one 1-cycle codec_wr_en, addr 0x07.
// - Read: push rd 0x05, controller returns 0x1A5 with busy pulse -> rsp_valid = 1,
//   rsp_addr = 0x05, rsp_data = 0x1A5, rsp_error = 0.
// - Backpressure: push 8 commands with rsp_ready = 0 -> cmd_ready = 0, fifo_level = 7
//   after the first pop. Only 1 codec_*_en until the rsp handshake.
// - NACK: missed_ack pulse during WAIT_DONE -> rsp_error = 1, rsp_data = 0.
// - Timeout: busy stuck high, TIMEOUT_CYCLES = 100 -> rsp_error = 1 exactly 100 cycles after ISSUE.
// - Reset mid-WAIT_DONE with 3 queued -> fifo_level = 0, no further codec_*_en, cmd_ready = 1.

Source files
------------

// File: rtl/codec_cmd_sequencer_if.sv
// Command/response bus between the register front end and codec_cmd_sequencer.
//   cmd_*  : front end -> sequencer, valid/ready command push (rd flag, 8-bit addr, 9-bit data)
//   rsp_*  : sequencer -> front end, valid/ready response (addr, 9-bit read data, error flag)
// master = front end side, slave = sequencer side.
interface codec_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rd;
  logic [7:0] cmd_addr;
  logic [8:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_addr;
  logic [8:0] rsp_data;
  logic       rsp_error;

  modport master (
    output cmd_valid, cmd_rd, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_error
  );

  modport slave (
    input  cmd_valid, cmd_rd, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_error
  );
endinterface

// File: rtl/codec_cmd_sequencer.sv
// CODEC command sequencer: queues register read/write commands in a FIFO and issues them one at
// a time to the CODEC controller, then returns read data / error through a response handshake.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   bus (slave)           cmd_* push handshake in, rsp_* response handshake out
//   fifo_level            entries currently queued
//   codec_rd_en/wr_en     1-cycle issue pulses to the controller
//   codec_reg_addr/_in    address / write data, held from issue until the next issue
//   codec_data_out(_valid) read data strobe from the controller
//   controller_busy       controller activity; an issued command is done after busy 1 -> 0
//   missed_ack            NACK indication, flags the outstanding command as errored
//   init_done/init_error  CODEC init status; either one allows issuing
//   wr_err_sticky         (only without CODEC_CMD_WR_RSP_EN) sticky write-error flag
//
// Build option CODEC_CMD_WR_RSP_EN: when defined, writes also produce a response (data 0).
// When undefined, writes finish silently and their errors land in wr_err_sticky.
module codec_cmd_sequencer #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  codec_cmd_sequencer_if.slave          bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          codec_rd_en,
  output logic                          codec_wr_en,
  output logic [7:0]                    codec_reg_addr,
  output logic [8:0]                    codec_data_in,
  input  logic [8:0]                    codec_data_out,
  input  logic                          codec_data_out_valid,
  input  logic                          controller_busy,
  input  logic                          missed_ack,
  input  logic                          init_done,
  input  logic                          init_error
`ifndef CODEC_CMD_WR_RSP_EN
  ,
  output logic                          wr_err_sticky
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitAcc, StWaitDone, StResp} state_e;

  // FIFO
  logic [17:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, push, pop;
  logic [17:0]   head;

  // Sequencer
  state_e        state_q, state_d;
  logic          cur_rd_q, cur_rd_d;
  logic [7:0]    addr_q, addr_d;
  logic [8:0]    wdata_q, wdata_d;
  logic          rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;
  logic [8:0]    rsp_data_q, rsp_data_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          timeout, finish;
`ifndef CODEC_CMD_WR_RSP_EN
  logic          sticky_q, sticky_d;
`endif

  assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  // No bypass: full blocks the push even if this cycle pops.
  assign push  = bus.cmd_valid & ~full;
  assign pop   = (state_q == StIdle) & ~empty & (init_done | init_error) & ~controller_busy &
                 ~rsp_valid_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.cmd_rd, bus.cmd_addr, bus.cmd_data};
  end

  // timer_q counts cycles since the issue pulse: zeroed on entry to ISSUE, so it equals
  // TIMEOUT_CYCLES in the cycle the error becomes visible.
  assign timeout = ((state_q == StWaitAcc) || (state_q == StWaitDone)) &&
                   (timer_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    cur_rd_d    = cur_rd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_en_d     = 1'b0;
    wr_en_d     = 1'b0;
    timer_d     = timer_q;
    err_d       = err_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    finish      = 1'b0;
`ifndef CODEC_CMD_WR_RSP_EN
    sticky_d    = sticky_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d    = StIssue;
          cur_rd_d   = head[17];
          addr_d     = head[16:9];
          wdata_d    = head[8:0];
          rd_en_d    = head[17];
          wr_en_d    = ~head[17];
          timer_d    = '0;
          err_d      = 1'b0;
          rsp_data_d = '0;
        end
      end
      StIssue: begin
        state_d = StWaitAcc;
        timer_d = timer_q + 1'b1;
      end
      StWaitAcc, StWaitDone: begin
        timer_d = timer_q + 1'b1;
        // Only reads capture data, so write responses always carry 0.
        if (codec_data_out_valid && cur_rd_q) rsp_data_d = codec_data_out;
        if (missed_ack || timeout) err_d = 1'b1;
        if (timeout) begin
          finish = 1'b1;
        end else if (state_q == StWaitAcc) begin
          if (controller_busy) state_d = StWaitDone;
        end else if (!controller_busy) begin
          finish = 1'b1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (finish) begin
`ifdef CODEC_CMD_WR_RSP_EN
      state_d     = StResp;
      rsp_valid_d = 1'b1;
`else
      if (cur_rd_q) begin
        state_d     = StResp;
        rsp_valid_d = 1'b1;
      end else begin
        state_d = StIdle;
        if (err_d) sticky_d = 1'b1;
      end
`endif
    end

    if (err_d) rsp_data_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= StIdle;
      cur_rd_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      timer_q     <= '0;
      err_q       <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      cur_rd_q    <= cur_rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifndef CODEC_CMD_WR_RSP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sticky_q <= 1'b0;
    else          sticky_q <= sticky_d;
  end
  assign wr_err_sticky = sticky_q;
`endif

  assign bus.cmd_ready  = ~full;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_addr   = addr_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_error  = err_q;
  assign fifo_level     = count_q;
  assign codec_rd_en    = rd_en_q;
  assign codec_wr_en    = wr_en_q;
  assign codec_reg_addr = addr_q;
  assign codec_data_in  = wdata_q;

endmodule

// File: tb/tb_codec_cmd_sequencer.sv
// Self-checking bench for codec_cmd_sequencer with a behavioural CODEC controller model.
module tb_codec_cmd_sequencer;
  localparam int unsigned Depth = 8;
  localparam int unsigned Tmo   = 100;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  codec_cmd_sequencer_if bus();
  logic [$clog2(Depth):0] fifo_level;
  logic       codec_rd_en, codec_wr_en;
  logic [7:0] codec_reg_addr;
  logic [8:0] codec_data_in, codec_data_out;
  logic       codec_data_out_valid, controller_busy, missed_ack, init_done, init_error;
`ifndef CODEC_CMD_WR_RSP_EN
  logic       wr_err_sticky;
`endif

  codec_cmd_sequencer #(.FIFO_DEPTH(Depth), .TIMEOUT_CYCLES(Tmo)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .bus                 (bus),
    .fifo_level          (fifo_level),
    .codec_rd_en         (codec_rd_en),
    .codec_wr_en         (codec_wr_en),
    .codec_reg_addr      (codec_reg_addr),
    .codec_data_in       (codec_data_in),
    .codec_data_out      (codec_data_out),
    .codec_data_out_valid(codec_data_out_valid),
    .controller_busy     (controller_busy),
    .missed_ack          (missed_ack),
    .init_done           (init_done),
    .init_error          (init_error)
`ifndef CODEC_CMD_WR_RSP_EN
    ,
    .wr_err_sticky       (wr_err_sticky)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] rd_val(input logic [7:0] a);
    return 9'h1A0 ^ {1'b0, a};
  endfunction

  typedef struct packed {logic rd; logic [7:0] addr; logic [8:0] data;} iss_t;
  typedef struct packed {logic [7:0] addr; logic [8:0] data; logic err;} rsp_t;
  iss_t iss_q[$];
  rsp_t rsp_q[$];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: issue pulses and response handshakes, checked against the scoreboards.
  int unsigned en_count = 0, last_issue_cyc = 0, err_rise_cyc = 0;
  logic prev_en = 1'b0, prev_err = 1'b0;
  iss_t mon_ie;
  rsp_t mon_re;
  always @(negedge clk) begin
    if (codec_rd_en || codec_wr_en) begin
      en_count++;
      last_issue_cyc = cyc;
      check_eq("en_pulse_width", prev_en, 0);
      check_eq("issue_expected", iss_q.size() != 0, 1);
      if (iss_q.size() != 0) begin
        mon_ie = iss_q.pop_front();
        check_eq("issue_rd", codec_rd_en, mon_ie.rd);
        check_eq("issue_wr", codec_wr_en, !mon_ie.rd);
        check_eq("issue_addr", codec_reg_addr, mon_ie.addr);
        if (!mon_ie.rd) check_eq("issue_wdata", codec_data_in, mon_ie.data);
      end
    end
    prev_en = codec_rd_en | codec_wr_en;
    if (bus.rsp_error && !prev_err) err_rise_cyc = cyc;
    prev_err = bus.rsp_error;
    if (bus.rsp_valid && bus.rsp_ready) begin
      check_eq("rsp_expected", rsp_q.size() != 0, 1);
      if (rsp_q.size() != 0) begin
        mon_re = rsp_q.pop_front();
        check_eq("rsp_addr", bus.rsp_addr, mon_re.addr);
        check_eq("rsp_data", bus.rsp_data, mon_re.data);
        check_eq("rsp_error", bus.rsp_error, mon_re.err);
      end
    end
  end

  // Controller model. ctl_mode: 0 normal, 1 NACK after data, 2 hold busy high.
  int   ctl_mode = 0;
  logic ctl_rd;
  logic [7:0] ctl_addr;
  initial begin
    controller_busy      = 1'b0;
    codec_data_out       = '0;
    codec_data_out_valid = 1'b0;
    missed_ack           = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && (codec_rd_en || codec_wr_en)) begin
        ctl_rd   = codec_rd_en;
        ctl_addr = codec_reg_addr;
        @(negedge clk);
        controller_busy = 1'b1;
        if (ctl_mode == 2) begin
          while (ctl_mode == 2 && reset_n) @(negedge clk);
        end else begin
          repeat (2) @(negedge clk);
          if (ctl_rd) begin
            codec_data_out       = rd_val(ctl_addr);
            codec_data_out_valid = 1'b1;
            @(negedge clk);
            codec_data_out_valid = 1'b0;
          end
          if (ctl_mode == 1) begin
            missed_ack = 1'b1;
            @(negedge clk);
            missed_ack = 1'b0;
          end
          @(negedge clk);
        end
        controller_busy = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic rd, input logic [7:0] a, input logic [8:0] d,
                          input logic err);
    int   t;
    logic do_rsp;
    iss_t ie;
    rsp_t re;
    bus.cmd_valid = 1'b1;
    bus.cmd_rd    = rd;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    t = 0;
    @(negedge clk);
    while (!bus.cmd_ready && t < 500) begin
      t++;
      @(negedge clk);
    end
    check_eq("push_accepted", bus.cmd_ready, 1);
    ie.rd = rd;
    ie.addr = a;
    ie.data = d;
    iss_q.push_back(ie);
`ifdef CODEC_CMD_WR_RSP_EN
    do_rsp = 1'b1;
`else
    do_rsp = rd;
`endif
    if (do_rsp) begin
      re.addr = a;
      re.data = (rd && !err) ? rd_val(a) : 9'h000;
      re.err  = err;
      rsp_q.push_back(re);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while ((iss_q.size() != 0 || rsp_q.size() != 0 || fifo_level != 0) && t < budget) begin
      tick(1);
      t++;
    end
    check_eq("drain_in_time", t < budget, 1);
    tick(10);
  endtask

  int unsigned base;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_rd    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b1;
    init_done     = 1'b0;
    init_error    = 1'b0;
    tick(3);
    check_eq("rst_cmd_ready", bus.cmd_ready, 1);
    check_eq("rst_rsp_valid", bus.rsp_valid, 0);
    check_eq("rst_rsp_error", bus.rsp_error, 0);
    check_eq("rst_rsp_data", bus.rsp_data, 0);
    check_eq("rst_rsp_addr", bus.rsp_addr, 0);
    check_eq("rst_fifo_level", fifo_level, 0);
    check_eq("rst_rd_en", codec_rd_en, 0);
    check_eq("rst_wr_en", codec_wr_en, 0);
    check_eq("rst_reg_addr", codec_reg_addr, 0);
    check_eq("rst_data_in", codec_data_in, 0);
`ifndef CODEC_CMD_WR_RSP_EN
    check_eq("rst_sticky", wr_err_sticky, 0);
`endif
    reset_n = 1'b1;
    tick(2);

    // Init gating
    push_cmd(1'b0, 8'h07, 9'h123, 1'b0);
    tick(20);
    check_eq("init_gate_no_en", en_count, 0);
    check_eq("init_gate_level", fifo_level, 1);
    init_done = 1'b1;
    wait_drain(50);
    check_eq("init_gate_one_en", en_count, 1);

    // Reads and a mixed burst
    push_cmd(1'b1, 8'h05, 9'h000, 1'b0);
    wait_drain(100);
    push_cmd(1'b0, 8'h10, 9'h0AA, 1'b0);
    push_cmd(1'b1, 8'h22, 9'h000, 1'b0);
    push_cmd(1'b1, 8'h7F, 9'h000, 1'b0);
    wait_drain(300);

    // Backpressure: fill while gated, then only one issue until the response is taken
    init_done = 1'b0;
    bus.rsp_ready = 1'b0;
    base = en_count;
    for (int i = 0; i < 8; i++) push_cmd(1'b1, 8'h80 + 8'(i), 9'h000, 1'b0);
    tick(2);
    check_eq("bp_full_not_ready", bus.cmd_ready, 0);
    check_eq("bp_full_level", fifo_level, 8);
    init_done = 1'b1;
    tick(30);
    check_eq("bp_level_after_pop", fifo_level, 7);
    check_eq("bp_single_issue", en_count - base, 1);
    check_eq("bp_rsp_held", bus.rsp_valid, 1);
    check_eq("bp_ready_again", bus.cmd_ready, 1);
    bus.rsp_ready = 1'b1;
    wait_drain(800);
    check_eq("bp_all_issued", en_count - base, 8);

    // NACK, issuing enabled by init_error alone
    init_done  = 1'b0;
    init_error = 1'b1;
    ctl_mode   = 1;
    push_cmd(1'b1, 8'h33, 9'h000, 1'b1);
    push_cmd(1'b0, 8'h44, 9'h155, 1'b1);
    wait_drain(300);
`ifndef CODEC_CMD_WR_RSP_EN
    check_eq("nack_wr_sticky", wr_err_sticky, 1);
`endif
    ctl_mode   = 0;
    init_done  = 1'b1;
    init_error = 1'b0;

    // Timeout with busy stuck high
    ctl_mode = 2;
    push_cmd(1'b1, 8'h5A, 9'h000, 1'b1);
    wait_drain(400);
    check_eq("tmo_latency", err_rise_cyc - last_issue_cyc, Tmo);
    ctl_mode = 0;
    tick(5);

    // Reset in WAIT_DONE with three queued
    ctl_mode = 2;
    base = en_count;
    push_cmd(1'b1, 8'h60, 9'h000, 1'b0);
    push_cmd(1'b1, 8'h61, 9'h000, 1'b0);
    push_cmd(1'b1, 8'h62, 9'h000, 1'b0);
    push_cmd(1'b1, 8'h63, 9'h000, 1'b0);
    tick(3);
    check_eq("mid_level_before_rst", fifo_level, 3);
    reset_n = 1'b0;
    iss_q.delete();
    rsp_q.delete();
    ctl_mode = 0;
    tick(1);
    check_eq("mid_rst_level", fifo_level, 0);
    check_eq("mid_rst_ready", bus.cmd_ready, 1);
    check_eq("mid_rst_rsp_valid", bus.rsp_valid, 0);
`ifndef CODEC_CMD_WR_RSP_EN
    check_eq("mid_rst_sticky", wr_err_sticky, 0);
`endif
    reset_n = 1'b1;
    tick(40);
    check_eq("post_rst_no_en", en_count - base, 1);
    check_eq("post_rst_level", fifo_level, 0);
    check_eq("post_rst_ready", bus.cmd_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
